spi_reg_responder: RTL and testbench
====================================

Name: spi_reg_responder

Overview:
- SPI mode-0 target (responder) that turns an external SPI initiator's byte stream into single-cycle register read and write strobes in the core clock domain.
- It is the target-side counterpart of the management core's SPI initiator (spi_csb, spi_sck, spi_sdo, spi_sdi). It lets a bench or host reach a byte-wide register bank through the mgmt GPIO SPI pins.
- SCK, CSB and SDI are oversampled by wb_clk_i; SCK is not used as a clock.

Parameters:
- ADDR_W, 8, register address width; the address wraps modulo 2^ADDR_W.
- SYNC_STAGES, 2, synchronizer depth on spi_csb, spi_sck and spi_sdi (minimum 2).

Ports:
- wb_clk_i  input  1  core clock.
- wb_rst_i  input  1  synchronous, active-high reset.
- spi_csb  input  1  chip select, active low.
- spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0). Maximum frequency is wb_clk_i/8.
- spi_sdi  input  1  initiator-to-target data, MSB first.
- spi_sdo  output  1  target-to-initiator data, MSB first.
- spi_sdoenb  output  1  output enable for spi_sdo, active low.
- reg_addr  output  ADDR_W  register address.
- reg_wdata  output  8  write data.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data; must be valid exactly one cycle after reg_re.
- busy  output  1  high while a transaction is in progress (state is not IDLE).

Behaviour:
- **Reset values:** spi_sdo=0, spi_sdoenb=1, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0. State=IDLE, bit counter=0. Synchronizers are cleared with csb=1 and sck=0.
- **Reset mid-transaction:** abandon immediately with no strobe. The transaction resumes only after CSB is seen high and then low again.
- **Edge detection:** on the synchronized signals. SCK rise = sample SDI. SCK fall = shift SDO.
- **Byte assembly:** 3-bit bit counter; bytes are assembled MSB first. A byte completes on its 8th SCK rise.
- **States:**
  - IDLE: CSB fall -> CMD.
  - CMD, byte 0 is the command:
    - bit7 = write, bit6 = read, bits5:0 must be 0.
    - bits5:0 nonzero -> IGNORE.
    - Otherwise latch the W/R flags and go to ADDR.
    - 0x00 is a legal no-op stream: go to ADDR, then DATA with no strobes.
  - ADDR, byte 1 is the start address (low ADDR_W bits; upper bits are ignored when ADDR_W<8):
    - On completion, set reg_addr.
    - If R, pulse reg_re the same cycle and load reg_rdata into the TX shift register one cycle later.
    - Go to DATA.
  - DATA, each completed byte does the following:
    - If W: pulse reg_we with reg_addr=current address and reg_wdata=received byte.
    - Next cycle: reg_addr <= reg_addr+1, wrapping at 2^ADDR_W.
    - If R: pulse reg_re at the new address in that cycle and reload the TX register one cycle later (prefetch).
  - IGNORE: no strobes, sdoenb stays 1, until CSB rises.
- **Read output:**
  - spi_sdoenb=0 only in the DATA state of a read command.
  - The MSB of each read byte drives spi_sdo from the first SCK fall after the byte is loaded.
  - Subsequent bits change on SCK falls. The initiator samples on rises.
- **Read/write command (0xC0):** each byte is written to addr N while byte N+1 is prefetched for the read stream. Data read back is the pre-write value of the next address.
- **CSB rise in any state:**
  - Return to IDLE on the next cycle and set spi_sdoenb=1.
  - A partial byte is discarded: no reg_we, no address change.
- **CSB fall while busy:** cannot occur without a rise first; nothing extra to handle.
- **SCK while CSB high:** ignored.
- **Strobes:** reg_we and reg_re are never high for more than one cycle per byte.

Optional Feature:
- Macro: SPI_RESP_IRQ_EN.
- With it defined, the block adds port `irq  output  1`, reset value 0.
- irq pulses high for exactly one cycle, one cycle after the CSB rise that ends a transaction in which at least one reg_we was issued.
- No pulse follows transactions that were aborted, ignored, or read-only.
- Without the macro the port and its logic do not exist. All other behaviour is identical.

Test Plan:
- Write: CSB low, send 0x80, 0x10, 0xA5, 0x3C, CSB high.
  - Expect reg_we at addr 0x10 with data 0xA5, then at addr 0x11 with data 0x3C.
  - Exactly 2 write strobes; spi_sdoenb stays 1 throughout.
- Read: bank preloaded with 0x20=0x5A and 0x21=0xC3. Send 0x40, 0x20, then 16 dummy clocks.
  - Expect spi_sdo bytes 0x5A then 0xC3.
  - reg_re at 0x20, 0x21 and 0x22 (prefetch).
  - spi_sdoenb=0 only during the DATA state.
- Wraparound: with ADDR_W=8, send 0x80, 0xFF, 0x11, 0x22.
  - Expect writes 0xFF<-0x11 and 0x00<-0x22.
- Abort: send 0x80, 0x05, then 5 bits of a data byte, then CSB high.
  - Expect no reg_we and busy=0 one cycle after CSB is seen high.
  - A following valid transaction works.
- Bad command and reset:
  - Command 0x81 -> no strobes and spi_sdoenb=1 for the whole frame.
  - Separately, assert wb_rst_i during the 3rd data byte -> all outputs return to reset values and no strobe is issued.
- With SPI_RESP_IRQ_EN:
  - The first write test yields exactly one irq pulse after CSB rise.
  - The read test and the abort test yield none.

Source files
------------

// File: rtl/spi_reg_responder.sv
// -----------------------------------------------------------------------------
// spi_reg_responder
//
// SPI mode-0 target that turns an initiator's byte stream into single-cycle
// register read/write strobes in the wb_clk_i domain. SCK, CSB and SDI are
// oversampled; SCK is never used as a clock (max SCK = wb_clk_i / 8).
//
// Frame: byte 0 = command (bit7 write, bit6 read, bits5:0 must be zero),
//        byte 1 = start address, then data bytes at auto-incrementing
//        addresses. Reads are prefetched one byte ahead.
//
// Ports:
//   wb_clk_i, wb_rst_i   core clock, synchronous active-high reset
//   spi_csb/sck/sdi      SPI inputs (asynchronous, synchronized here)
//   spi_sdo, spi_sdoenb  SPI read data and its active-low output enable
//   reg_addr/wdata/we/re register bank access (one-cycle strobes)
//   reg_rdata            bank read data, valid one cycle after reg_re
//   busy                 high while a frame is in progress
//   irq                  (only with SPI_RESP_IRQ_EN) one-cycle pulse after a
//                        frame that issued at least one write
//
// Optional feature macro: SPI_RESP_IRQ_EN
// -----------------------------------------------------------------------------
module spi_reg_responder #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              spi_csb,
    input  logic              spi_sck,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdoenb,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
`ifdef SPI_RESP_IRQ_EN
    output logic              irq,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_IGNORE
    } state_t;

    // Synchronizer bit order is {sdi, sck, csb}; cleared to csb=1, sck=0.
    localparam logic [2:0] SYNC_RST = 3'b001;
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [2:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge wb_clk_i) begin
                    if (wb_rst_i)
                        stage_reg <= SYNC_RST;
                    else
                        stage_reg <= {spi_sdi, spi_sck, spi_csb};
                end
            end else begin : g_rest
                always_ff @(posedge wb_clk_i) begin
                    if (wb_rst_i)
                        stage_reg <= SYNC_RST;
                    else
                        stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    logic csb_s, sck_s, sdi_s;
    assign csb_s = g_sync[SYNC_STAGES-1].stage_reg[0];
    assign sck_s = g_sync[SYNC_STAGES-1].stage_reg[1];
    assign sdi_s = g_sync[SYNC_STAGES-1].stage_reg[2];

    state_t              state_reg;
    logic                csb_q_reg, sck_q_reg;
    logic [2:0]          bit_cnt_reg;
    logic [7:0]          rx_reg, tx_reg;
    logic                wr_reg, rd_reg;
    logic                inc_pend_reg, load_pend_reg;
    logic                armed_reg;
    logic [FLUSH_W-1:0]  flush_cnt_reg;
    logic                sdo_reg, sdoenb_reg, we_reg, re_reg, busy_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [7:0]          wdata_reg;
`ifdef SPI_RESP_IRQ_EN
    logic                wrote_reg, irq_reg;
`endif

    // SCK edges only count while CSB is low.
    logic sck_rise, sck_fall, csb_fall, csb_rise, byte_done;
    logic [7:0] rx_next;
    assign sck_rise  = sck_s & ~sck_q_reg & ~csb_s;
    assign sck_fall  = ~sck_s & sck_q_reg & ~csb_s;
    assign csb_fall  = ~csb_s & csb_q_reg;
    assign csb_rise  = csb_s & ~csb_q_reg;
    assign rx_next   = {rx_reg[6:0], sdi_s};
    assign byte_done = sck_rise && (bit_cnt_reg == 3'd7);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg     <= S_IDLE;
            csb_q_reg     <= 1'b1;
            sck_q_reg     <= 1'b0;
            bit_cnt_reg   <= 3'd0;
            rx_reg        <= 8'd0;
            tx_reg        <= 8'd0;
            wr_reg        <= 1'b0;
            rd_reg        <= 1'b0;
            inc_pend_reg  <= 1'b0;
            load_pend_reg <= 1'b0;
            armed_reg     <= 1'b0;
            flush_cnt_reg <= '0;
            sdo_reg       <= 1'b0;
            sdoenb_reg    <= 1'b1;
            we_reg        <= 1'b0;
            re_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= 8'd0;
`ifdef SPI_RESP_IRQ_EN
            wrote_reg     <= 1'b0;
            irq_reg       <= 1'b0;
`endif
        end else begin
            csb_q_reg     <= csb_s;
            sck_q_reg     <= sck_s;
            we_reg        <= 1'b0;
            re_reg        <= 1'b0;
            inc_pend_reg  <= 1'b0;
            // Bank returns data the cycle after reg_re; capture it then.
            load_pend_reg <= re_reg;
`ifdef SPI_RESP_IRQ_EN
            irq_reg       <= 1'b0;
`endif

            // After reset the synchronizers hold a fake "CSB high"; only trust
            // CSB once the chain has refilled, and require a real high level
            // before accepting a fall so an interrupted frame cannot resume.
            if (flush_cnt_reg != FLUSH_DONE)
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            else if (csb_s)
                armed_reg <= 1'b1;

            // Post-byte address increment, with prefetch read at the new address.
            if (inc_pend_reg) begin
                addr_reg <= addr_reg + 1'b1;
                re_reg   <= rd_reg;
            end

            if (load_pend_reg)
                tx_reg <= reg_rdata;
            else if (sck_fall && state_reg == S_DATA && rd_reg) begin
                sdo_reg <= tx_reg[7];
                tx_reg  <= {tx_reg[6:0], 1'b0};
            end

            if (sck_rise && state_reg != S_IDLE) begin
                rx_reg      <= rx_next;
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (csb_fall && armed_reg) begin
                        state_reg   <= S_CMD;
                        busy_reg    <= 1'b1;
                        bit_cnt_reg <= 3'd0;
                        wr_reg      <= 1'b0;
                        rd_reg      <= 1'b0;
`ifdef SPI_RESP_IRQ_EN
                        wrote_reg   <= 1'b0;
`endif
                    end
                end
                S_CMD: begin
                    if (byte_done) begin
                        if (rx_next[5:0] != 6'd0)
                            state_reg <= S_IGNORE;
                        else begin
                            wr_reg    <= rx_next[7];
                            rd_reg    <= rx_next[6];
                            state_reg <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (byte_done) begin
                        addr_reg   <= rx_next[ADDR_W-1:0];
                        re_reg     <= rd_reg;
                        sdoenb_reg <= ~rd_reg;
                        state_reg  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (byte_done) begin
                        if (wr_reg) begin
                            we_reg    <= 1'b1;
                            wdata_reg <= rx_next;
`ifdef SPI_RESP_IRQ_EN
                            wrote_reg <= 1'b1;
`endif
                        end
                        inc_pend_reg <= 1'b1;
                    end
                end
                default: ;
            endcase

            // CSB rise ends any frame; a partial byte is simply dropped.
            if (csb_rise && state_reg != S_IDLE) begin
                state_reg   <= S_IDLE;
                busy_reg    <= 1'b0;
                sdoenb_reg  <= 1'b1;
                sdo_reg     <= 1'b0;
                bit_cnt_reg <= 3'd0;
`ifdef SPI_RESP_IRQ_EN
                irq_reg     <= wrote_reg;
`endif
            end
        end
    end

    assign spi_sdo    = sdo_reg;
    assign spi_sdoenb = sdoenb_reg;
    assign reg_addr   = addr_reg;
    assign reg_wdata  = wdata_reg;
    assign reg_we     = we_reg;
    assign reg_re     = re_reg;
    assign busy       = busy_reg;
`ifdef SPI_RESP_IRQ_EN
    assign irq        = irq_reg;
`endif

endmodule

// File: tb/tb_spi_reg_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_responder
//
// Drives SPI frames into spi_reg_responder, hosts a byte-wide register bank
// on its strobes, and compares observed strobes/read data against expected
// values derived from the frame contents and a shadow copy of the bank.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_reg_responder;

    localparam int HALF = 5;   // SCK half period in wb_clk_i cycles

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       spi_csb  = 1'b1;
    logic       spi_sck  = 1'b0;
    logic       spi_sdi  = 1'b0;
    logic       spi_sdo, spi_sdoenb, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
`ifdef SPI_RESP_IRQ_EN
    logic       irq;
`endif

    always #5 wb_clk_i = ~wb_clk_i;

    spi_reg_responder #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .spi_csb    (spi_csb),
        .spi_sck    (spi_sck),
        .spi_sdi    (spi_sdi),
        .spi_sdo    (spi_sdo),
        .spi_sdoenb (spi_sdoenb),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
`ifdef SPI_RESP_IRQ_EN
        .irq        (irq),
`endif
        .busy       (busy)
    );

    // Register bank environment: registered read, one cycle after reg_re.
    logic [7:0] bank [256];
    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = 8'd0, poke_data = 8'd0;
    always @(posedge wb_clk_i) begin
        if (poke_en)
            bank[poke_addr] <= poke_data;
        else if (reg_we)
            bank[reg_addr] <= reg_wdata;
        if (reg_re)
            reg_rdata <= bank[reg_addr];
    end

    // Strobe monitor.
    logic [15:0] we_q[$];
    logic [7:0]  re_q[$];
    int          enb_low_cnt = 0;
    int          irq_cnt = 0;
    int          strobe_dbl = 0;
    logic        clr_mon = 1'b0;
    logic        we_prev = 1'b0, re_prev = 1'b0;
    always @(posedge wb_clk_i) begin
        we_prev <= reg_we;
        re_prev <= reg_re;
        if ((reg_we && we_prev) || (reg_re && re_prev))
            strobe_dbl++;
        if (clr_mon) begin
            we_q.delete();
            re_q.delete();
            enb_low_cnt = 0;
            irq_cnt = 0;
        end else begin
            if (reg_we) we_q.push_back({reg_addr, reg_wdata});
            if (reg_re) re_q.push_back(reg_addr);
            if (!spi_sdoenb) enb_low_cnt++;
`ifdef SPI_RESP_IRQ_EN
            if (irq) irq_cnt++;
`endif
        end
    end

    // Shadow of the bank and frame buffers.
    logic [7:0] exp_mem [256];
    logic [7:0] tx_buf [16];
    logic [7:0] rx_buf [16];
    logic       enb_buf [16];
    logic       busy_pre, busy_post;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge wb_clk_i) clr_mon = 1'b1;
        @(negedge wb_clk_i) clr_mon = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge wb_clk_i);
        poke_en   = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic enb0);
        rx   = 8'd0;
        enb0 = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = tx[7-i];
            repeat (HALF) @(negedge wb_clk_i);
            rx = {rx[6:0], spi_sdo};
            if (i == 0) enb0 = spi_sdoenb;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge wb_clk_i);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n, input int last_bits);
        spi_csb = 1'b0;
        repeat (HALF) @(negedge wb_clk_i);
        for (int b = 0; b < n; b++)
            spi_byte(tx_buf[b], (b == n - 1) ? last_bits : 8, rx_buf[b], enb_buf[b]);
        repeat (HALF) @(negedge wb_clk_i);
        busy_pre = busy;
        spi_csb  = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        busy_post = busy;
        repeat (4 * HALF) @(negedge wb_clk_i);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sdo"},    {31'd0, spi_sdo},    32'd0);
        check({tag, "_sdoenb"}, {31'd0, spi_sdoenb}, 32'd1);
        check({tag, "_addr"},   {24'd0, reg_addr},   32'd0);
        check({tag, "_wdata"},  {24'd0, reg_wdata},  32'd0);
        check({tag, "_we_re"},  {30'd0, reg_we, reg_re}, 32'd0);
        check({tag, "_busy"},   {31'd0, busy},       32'd0);
`ifdef SPI_RESP_IRQ_EN
        check({tag, "_irq"},    {31'd0, irq},        32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    logic [7:0] cmd, addr, a, d, scratch;
    logic       enb_scratch, is_w, is_r;
    int         n;
    logic [7:0] cmd_pick [4];

    initial begin
        // Reset and fill the bank with random contents.
        repeat (3) @(negedge wb_clk_i);
        for (int i = 0; i < 256; i++)
            poke(8'(i), 8'($urandom));
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check_reset_vals("reset");
        repeat (5) @(negedge wb_clk_i);

        // Write burst.
        clear_mon();
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h10; tx_buf[2] = 8'hA5; tx_buf[3] = 8'h3C;
        spi_frame(4, 8);
        check("wr_count", we_q.size(), 2);
        check("wr_0", {16'd0, we_q[0]}, 32'h10A5);
        check("wr_1", {16'd0, we_q[1]}, 32'h113C);
        check("wr_sdoenb_low_cycles", enb_low_cnt, 0);
        check("wr_no_read", re_q.size(), 0);
        check("wr_busy_during", {31'd0, busy_pre}, 32'd1);
        check("wr_busy_after", {31'd0, busy_post}, 32'd0);
`ifdef SPI_RESP_IRQ_EN
        check("wr_irq_cycles", irq_cnt, 1);
`endif
        exp_mem[8'h10] = 8'hA5;
        exp_mem[8'h11] = 8'h3C;

        // Read burst with prefetch.
        poke(8'h20, 8'h5A);
        poke(8'h21, 8'hC3);
        clear_mon();
        tx_buf[0] = 8'h40; tx_buf[1] = 8'h20; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
        spi_frame(4, 8);
        check("rd_byte0", {24'd0, rx_buf[2]}, 32'h5A);
        check("rd_byte1", {24'd0, rx_buf[3]}, 32'hC3);
        check("rd_re_count", re_q.size(), 3);
        check("rd_re_0", {24'd0, re_q[0]}, 32'h20);
        check("rd_re_1", {24'd0, re_q[1]}, 32'h21);
        check("rd_re_2", {24'd0, re_q[2]}, 32'h22);
        check("rd_enb_cmd", {31'd0, enb_buf[0]}, 32'd1);
        check("rd_enb_addr", {31'd0, enb_buf[1]}, 32'd1);
        check("rd_enb_data0", {31'd0, enb_buf[2]}, 32'd0);
        check("rd_enb_data1", {31'd0, enb_buf[3]}, 32'd0);
        check("rd_enb_after", {31'd0, spi_sdoenb}, 32'd1);
        check("rd_no_write", we_q.size(), 0);
`ifdef SPI_RESP_IRQ_EN
        check("rd_irq_cycles", irq_cnt, 0);
`endif

        // Address wraparound.
        clear_mon();
        tx_buf[0] = 8'h80; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h11; tx_buf[3] = 8'h22;
        spi_frame(4, 8);
        check("wrap_count", we_q.size(), 2);
        check("wrap_0", {16'd0, we_q[0]}, 32'hFF11);
        check("wrap_1", {16'd0, we_q[1]}, 32'h0022);
        exp_mem[8'hFF] = 8'h11;
        exp_mem[8'h00] = 8'h22;

        // Abort with a partial data byte, then a good frame.
        clear_mon();
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h05; tx_buf[2] = 8'hE7;
        spi_frame(3, 5);
        check("abort_no_write", we_q.size(), 0);
        check("abort_busy_during", {31'd0, busy_pre}, 32'd1);
        check("abort_busy_after", {31'd0, busy_post}, 32'd0);
        check("abort_addr_kept", {24'd0, reg_addr}, 32'h05);
`ifdef SPI_RESP_IRQ_EN
        check("abort_irq_cycles", irq_cnt, 0);
`endif
        clear_mon();
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h07; tx_buf[2] = 8'h5E;
        spi_frame(3, 8);
        check("post_abort_count", we_q.size(), 1);
        check("post_abort_wr", {16'd0, we_q[0]}, 32'h075E);
        exp_mem[8'h07] = 8'h5E;

        // Illegal command.
        clear_mon();
        tx_buf[0] = 8'h81; tx_buf[1] = 8'h10; tx_buf[2] = 8'hAA;
        spi_frame(3, 8);
        check("badcmd_strobes", we_q.size() + re_q.size(), 0);
        check("badcmd_sdoenb_low_cycles", enb_low_cnt, 0);
        check("badcmd_busy_during", {31'd0, busy_pre}, 32'd1);

        // Reset during the third data byte.
        clear_mon();
        spi_csb = 1'b0;
        repeat (HALF) @(negedge wb_clk_i);
        spi_byte(8'h80, 8, scratch, enb_scratch);
        spi_byte(8'h30, 8, scratch, enb_scratch);
        spi_byte(8'hD1, 8, scratch, enb_scratch);
        spi_byte(8'hD2, 8, scratch, enb_scratch);
        spi_byte(8'hD3, 4, scratch, enb_scratch);
        wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check_reset_vals("midrst");
        spi_byte(8'h3F, 4, scratch, enb_scratch);
        check("midrst_busy_tail", {31'd0, busy}, 32'd0);
        repeat (HALF) @(negedge wb_clk_i);
        spi_csb = 1'b1;
        repeat (4 * HALF) @(negedge wb_clk_i);
        check("midrst_count", we_q.size(), 2);
        check("midrst_wr_0", {16'd0, we_q[0]}, 32'h30D1);
        check("midrst_wr_1", {16'd0, we_q[1]}, 32'h31D2);
        exp_mem[8'h30] = 8'hD1;
        exp_mem[8'h31] = 8'hD2;
        clear_mon();
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h40; tx_buf[2] = 8'h77;
        spi_frame(3, 8);
        check("post_rst_wr", {16'd0, we_q[0]}, 32'h4077);
        exp_mem[8'h40] = 8'h77;

        // Randomized frames against the shadow bank.
        cmd_pick[0] = 8'h80; cmd_pick[1] = 8'h40; cmd_pick[2] = 8'hC0; cmd_pick[3] = 8'h00;
        for (int it = 0; it < 10; it++) begin
            cmd  = cmd_pick[$urandom_range(0, 3)];
            addr = 8'($urandom);
            n    = $urandom_range(1, 3);
            is_w = cmd[7];
            is_r = cmd[6];
            tx_buf[0] = cmd;
            tx_buf[1] = addr;
            for (int i = 0; i < n; i++) tx_buf[2+i] = 8'($urandom);
            clear_mon();
            spi_frame(n + 2, 8);
            check($sformatf("rnd%0d_cmd%0h_we_count", it, cmd), we_q.size(), is_w ? n : 0);
            check($sformatf("rnd%0d_cmd%0h_re_count", it, cmd), re_q.size(), is_r ? n + 1 : 0);
            for (int i = 0; i < n; i++) begin
                a = addr + 8'(i);
                d = tx_buf[2+i];
                if (is_r)
                    check($sformatf("rnd%0d_rd_%0h", it, a), {24'd0, rx_buf[2+i]}, {24'd0, exp_mem[a]});
                if (is_w) begin
                    check($sformatf("rnd%0d_wr_%0h", it, a), {16'd0, we_q[i]}, {16'd0, a, d});
                    exp_mem[a] = d;
                end
            end
        end

        check("strobe_single_cycle", strobe_dbl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
